multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style sequencing FSM for the multicycle RV32I subset datapath. The subset is lw, sw, R-type, I-type ALU, beq and jal.
- Sits beside the shared-memory datapath. Drives the PC, IR, register-file and memory enables, plus the ALU operand and result muxes, one state per cycle.
- Adds a memory-ready handshake so a slow unified memory can stall fetch and data accesses.
- Counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0], taken from the IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access requested
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format, combinational from op: lw/I = 00, sw = 01, beq = 10, jal = 11, other = 00
- ALUControl  out  3  ALU operation: add 000, sub 001, and 010, or 011, slt 101
- InstrRet  out  CNT_W  retired-instruction count
- Illegal  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset:
  - reset_n low forces state FETCH and InstrRet 0.
  - While reset_n is low, PCWrite, IRWrite, MemWrite, RegWrite and MemReq are all 0. Mux selects take their FETCH values.
- States and outputs (any output not listed is 0):
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=MemReady. Holds in FETCH until MemReady=1, then goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - lw or sw: MEMADR
    - R-type: EXECUTER
    - I-type: EXECUTEI
    - jal: JAL
    - beq: BEQ
    - other: FETCH
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady=1, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1. Holds, with MemWrite kept high, until MemReady=1, then goes to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next is ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next is FETCH.
- ALU decode:
  - ALUOp 00 gives add; ALUOp 01 gives sub.
  - ALUOp 10 decodes funct3:
    - 000: sub only when op[5] and funct7b5 are both 1, otherwise add
    - 010: slt
    - 110: or
    - 111: and
    - any other funct3: add
- Latency with zero wait states: beq 3 cycles; R-type, I-type, sw and jal 4 cycles; lw 5 cycles. Each MemReady=0 cycle adds one cycle.
- InstrRet:
  - Increments by 1 on each retiring transition: MEMWB to FETCH, MEMWRITE to FETCH with MemReady=1, ALUWB to FETCH, BEQ to FETCH.
  - Wraps modulo 2^CNT_W.
- MemReady is ignored in every state without MemReq.
- An asynchronous reset in the middle of an instruction aborts it: no retire count, and all enables drop immediately.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE goes to state TRAP. TRAP asserts no enables and is held until reset.
  - Illegal=1 from the cycle after DECODE until reset.
- Undefined:
  - An unknown op goes DECODE to FETCH as a no-op and does not increment InstrRet.
  - Illegal is tied to 0.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration, 4-bit encoding, FETCH=0
  - opcode constants: lw, sw, R, I, beq, jal
  - ALUOp constants
  - ALUControl constants
  - mux-select constants for ResultSrc, ALUSrcA and ALUSrcB
- Sub-module: reuse the existing alu_decoder unchanged, driven by op[5], funct3, funct7b5 and the FSM's ALUOp.
- ImmSrc decode is inline combinational logic.

Test Plan:
- Release reset with MemReady=1 → FETCH asserts IRWrite=PCWrite=1, ALUSrcB=10, ResultSrc=10. Assert reset_n low mid-lw → all enables 0 in the same cycle and InstrRet=0.
- lw (op 0000011), MemReady=1 throughout → exactly 5 cycles FETCH/DECODE/MEMADR/MEMREAD/MEMWB. RegWrite=1 with ResultSrc=01 in cycle 5. InstrRet goes 0→1.
- sw with MemReady=0 for 3 cycles in MEMWRITE → MemWrite held high for 4 cycles. Instruction takes 7 cycles. Exactly one InstrRet increment.
- R-type sub (funct3 000, funct7b5=1) → ALUControl=001 in EXECUTER. Then I-type addi with Instr[30]=1 → ALUControl=000. slt → 101.
- beq with Zero=1, then Zero=0 → PCWrite=1, then PCWrite=0, each in the 3rd cycle. jal → PCWrite in JAL, RegWrite in ALUWB, 4 cycles.
- op 1111111 → with MC_ILLEGAL_TRAP_EN: Illegal=1 and the FSM stays in TRAP for 10 cycles. Without the macro: returns to FETCH in cycle 3 and InstrRet is unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I-subset controller: state encoding,
// opcodes, ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps the FSM's ALUOp plus instruction fields onto an ALU operation.
module alu_decoder
    import mc_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (opb5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alucontrol = ALUC_SLT;
                    3'b110:  alucontrol = ALUC_OR;
                    3'b111:  alucontrol = ALUC_AND;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I-subset datapath with a memory-ready stall.
// Optional illegal-opcode trap state enabled by defining MC_ILLEGAL_TRAP_EN.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4; waits for MemReady
// DECODE     | register read, branch target into ALUOut
// MEMADR     | rs1 + imm address computation
// MEMREAD    | load data read; waits for MemReady
// MEMWB      | load data to register file (retires)
// MEMWRITE   | store write; waits for MemReady (retires)
// EXECUTER   | register-register ALU op
// EXECUTEI   | register-immediate ALU op
// ALUWB      | ALUOut to register file (retires)
// JAL        | PC <- target, OldPC+4 into ALUOut
// BEQ        | compare, PC <- target when equal (retires)
// TRAP       | unknown opcode, parked until reset
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic [CNT_W-1:0] InstrRet,
    output logic             Illegal
);

    state_t     state, state_nxt;
    logic [1:0] aluop;
    logic       mem_req_c, ir_write_c, pc_write_c, mem_write_c, reg_write_c;
    logic       retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_req_c   = 1'b0;
        AdrSrc      = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        aluop       = ALUOP_ADD;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                ir_write_c = MemReady;
                pc_write_c = MemReady;
                if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                AdrSrc    = 1'b1;
                if (MemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (MemReady) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                aluop      = ALUOP_SUB;
                pc_write_c = Zero;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Enables are gated by reset_n so they drop in the same cycle reset is asserted.
    assign MemReq   = mem_req_c   & reset_n;
    assign IRWrite  = ir_write_c  & reset_n;
    assign PCWrite  = pc_write_c  & reset_n;
    assign MemWrite = mem_write_c & reset_n;
    assign RegWrite = reg_write_c & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    InstrRet <= '0;
        else if (retire) InstrRet <= InstrRet + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign Illegal = (state == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (aluop),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; output vector per cycle is
// {MemReq,AdrSrc,IRWrite,PCWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] InstrRet;
    logic        Illegal;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .InstrRet   (InstrRet),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] E_RESET   = 15'b0_0_0_0_0_0_10_00_10_000;
    localparam logic [14:0] E_FETCH   = 15'b1_0_1_1_0_0_10_00_10_000;
    localparam logic [14:0] E_FETCH_W = 15'b1_0_0_0_0_0_10_00_10_000;
    localparam logic [14:0] E_DECODE  = 15'b0_0_0_0_0_0_00_01_01_000;
    localparam logic [14:0] E_MEMADR  = 15'b0_0_0_0_0_0_00_10_01_000;
    localparam logic [14:0] E_MEMRD   = 15'b1_1_0_0_0_0_00_00_00_000;
    localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_0_1_01_00_00_000;
    localparam logic [14:0] E_MEMWR   = 15'b1_1_0_0_1_0_00_00_00_000;
    localparam logic [14:0] E_ALUWB   = 15'b0_0_0_0_0_1_00_00_00_000;
    localparam logic [14:0] E_JAL     = 15'b0_0_0_1_0_0_00_01_10_000;
    localparam logic [14:0] E_EXR_SUB = 15'b0_0_0_0_0_0_00_10_00_001;
    localparam logic [14:0] E_EXR_SLT = 15'b0_0_0_0_0_0_00_10_00_101;
    localparam logic [14:0] E_EXR_AND = 15'b0_0_0_0_0_0_00_10_00_010;
    localparam logic [14:0] E_EXI_ADD = 15'b0_0_0_0_0_0_00_10_01_000;
    localparam logic [14:0] E_EXI_OR  = 15'b0_0_0_0_0_0_00_10_01_011;
    localparam logic [14:0] E_BEQ_T   = 15'b0_0_0_1_0_0_00_10_00_001;
    localparam logic [14:0] E_BEQ_N   = 15'b0_0_0_0_0_0_00_10_00_001;
    localparam logic [14:0] E_TRAP    = 15'b0_0_0_0_0_0_00_00_00_000;

    logic [14:0] obs;
    assign obs = {MemReq, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

    // Check the current cycle's outputs, then advance to the next negedge.
    task automatic step(input string tag, input logic [14:0] e);
        #1;
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
        @(negedge clk);
    endtask

    task automatic chk_vec(input string tag, input logic [14:0] e);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] e);
        n_assert++;
        assert (InstrRet === e) else begin
            n_fail++;
            $error("FAIL %s: InstrRet observed %0d expected %0d", tag, InstrRet, e);
        end
    endtask

    task automatic chk_imm(input string tag, input logic [1:0] e);
        #1;
        n_assert++;
        assert (ImmSrc === e) else begin
            n_fail++;
            $error("FAIL %s: ImmSrc observed %b expected %b", tag, ImmSrc, e);
        end
    endtask

    task automatic chk_ill(input string tag, input logic e);
        n_assert++;
        assert (Illegal === e) else begin
            n_fail++;
            $error("FAIL %s: Illegal observed %b expected %b", tag, Illegal, e);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        op       = 7'b0000011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_vec("reset_outputs", E_RESET);
        chk_cnt("reset_count", 32'd0);
        chk_ill("reset_illegal", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // lw, no wait states: 5 cycles
        chk_imm("imm_lw", 2'b00);
        step("lw_fetch", E_FETCH);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memread", E_MEMRD);
        chk_cnt("lw_count_before", 32'd0);
        step("lw_memwb", E_MEMWB);
        chk_cnt("lw_count_after", 32'd1);

        // sw with three wait cycles in MEMWRITE: 7 cycles
        op = 7'b0100011;
        chk_imm("imm_sw", 2'b01);
        step("sw_fetch", E_FETCH);
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        MemReady = 1'b0;
        step("sw_memwr_wait1", E_MEMWR);
        step("sw_memwr_wait2", E_MEMWR);
        step("sw_memwr_wait3", E_MEMWR);
        chk_cnt("sw_count_stalled", 32'd1);
        MemReady = 1'b1;
        step("sw_memwr_done", E_MEMWR);
        chk_cnt("sw_count_after", 32'd2);

        // R-type sub; MemReady low outside memory states must not matter
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        step("sub_fetch", E_FETCH);
        MemReady = 1'b0;
        step("sub_decode", E_DECODE);
        step("sub_exec", E_EXR_SUB);
        step("sub_aluwb", E_ALUWB);
        MemReady = 1'b1;
        chk_cnt("sub_count", 32'd3);

        // addi with Instr[30]=1 still adds
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        chk_imm("imm_addi", 2'b00);
        step("addi_fetch", E_FETCH);
        step("addi_decode", E_DECODE);
        step("addi_exec", E_EXI_ADD);
        step("addi_aluwb", E_ALUWB);
        chk_cnt("addi_count", 32'd4);

        op = 7'b0110011; funct3 = 3'b010; funct7b5 = 1'b0;
        step("slt_fetch", E_FETCH);
        step("slt_decode", E_DECODE);
        step("slt_exec", E_EXR_SLT);
        step("slt_aluwb", E_ALUWB);

        op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
        step("and_fetch", E_FETCH);
        step("and_decode", E_DECODE);
        step("and_exec", E_EXR_AND);
        step("and_aluwb", E_ALUWB);

        op = 7'b0010011; funct3 = 3'b110; funct7b5 = 1'b0;
        step("ori_fetch", E_FETCH);
        step("ori_decode", E_DECODE);
        step("ori_exec", E_EXI_OR);
        step("ori_aluwb", E_ALUWB);
        chk_cnt("alu_count", 32'd7);

        // beq taken then not taken: 3 cycles each
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        chk_imm("imm_beq", 2'b10);
        step("beqt_fetch", E_FETCH);
        step("beqt_decode", E_DECODE);
        step("beqt_beq", E_BEQ_T);
        chk_cnt("beqt_count", 32'd8);
        Zero = 1'b0;
        step("beqn_fetch", E_FETCH);
        step("beqn_decode", E_DECODE);
        step("beqn_beq", E_BEQ_N);
        chk_cnt("beqn_count", 32'd9);

        op = 7'b1101111;
        chk_imm("imm_jal", 2'b11);
        step("jal_fetch", E_FETCH);
        step("jal_decode", E_DECODE);
        step("jal_jal", E_JAL);
        step("jal_aluwb", E_ALUWB);
        chk_cnt("jal_count", 32'd10);

        // Fetch stall, then unknown opcode
        op = 7'b1111111;
        chk_imm("imm_illegal", 2'b00);
        MemReady = 1'b0;
        step("ill_fetch_wait", E_FETCH_W);
        MemReady = 1'b1;
        step("ill_fetch", E_FETCH);
        step("ill_decode", E_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            chk_ill("trap_illegal", 1'b1);
            step("trap_hold", E_TRAP);
        end
        chk_cnt("trap_count", 32'd10);
`else
        #1;
        chk_vec("ill_back_to_fetch", E_FETCH);
        chk_cnt("ill_count", 32'd10);
        chk_ill("ill_tied_low", 1'b0);
        @(negedge clk);
`endif

        // Reset pulse, then abort a lw in MEMREAD
        reset_n = 1'b0;
        #1;
        chk_vec("pulse_reset", E_RESET);
        chk_cnt("pulse_count", 32'd0);
        chk_ill("pulse_illegal", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        op = 7'b0000011;
        step("mid_fetch", E_FETCH);
        step("mid_decode", E_DECODE);
        step("mid_memadr", E_MEMADR);
        reset_n = 1'b0;
        #1;
        chk_vec("mid_reset_outputs", E_RESET);
        chk_cnt("mid_reset_count", 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step("post_fetch", E_FETCH);
        step("post_decode", E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
